stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000: clk cycles per count tick, legal range 2 to 2^24.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  level-sampled run request.
REQ-005 SHALL have port stop  input  1  level-sampled pause request.
REQ-006 SHALL have port clear  input  1  level-sampled return-to-zero request.
REQ-007 SHALL have port target  input  16  four BCD digits {d3,d2,d1,d0}; 16'h0000 means free-run.
REQ-008 SHALL have port digits  output  16  current four-digit BCD count {d3,d2,d1,d0}.
REQ-009 SHALL have port running  output  1  high exactly while state is RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse on target match.
REQ-011 SHALL have ports lap (input, 1, capture request) and lap_digits (output, 16, captured count), present only under LAP_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-013 SHALL resolve simultaneous requests with priority clear > stop > start.
REQ-014 SHALL, on clear in any state, zero digits and prescaler and enter IDLE next cycle.
REQ-015 SHALL, on start in IDLE, zero the prescaler and enter RUN; on start in PAUSE, enter RUN with the prescaler retained.
REQ-016 SHALL, on stop in RUN, enter PAUSE with digits and prescaler frozen; stop is ignored in other states.
REQ-017 SHALL ignore start in DONE; only clear or rst leave DONE.
REQ-018 SHALL advance the 24-bit prescaler only in RUN, counting 0..PRESCALE-1 and asserting an internal tick in the cycle it equals PRESCALE-1, then wrapping to 0.
REQ-019 SHALL, on tick, increment d0; digit n (n>0) SHALL increment in the same cycle only when all lower digits equal 9; any digit at 9 that increments SHALL wrap to 0.
REQ-020 SHALL wrap 9999 to 0000 on tick with no other side effect.
REQ-021 SHALL, when target is nonzero and the post-increment digits equal target, load those digits, pulse done for exactly that register update (done high the following cycle only), and enter DONE.
REQ-022 SHALL never match a target containing any nibble greater than 9 (behaves as free-run).
REQ-023 SHALL sample target only at tick; changing target mid-run takes effect at the next tick.
REQ-024 SHALL register all outputs; running SHALL rise one cycle after start is sampled.

Reset
REQ-025 SHALL, on rst, force state IDLE, digits 16'h0000, prescaler 0, running 0, done 0, lap_digits 16'h0000.
REQ-026 SHALL give rst priority over clear, stop, start, lap and tick, including mid-RUN.

Configuration
REQ-027 SHALL compile lap capture only when macro STOPWATCH_CTRL_LAP_EN is defined.
REQ-028 With STOPWATCH_CTRL_LAP_EN: lap high in RUN or PAUSE SHALL load lap_digits with the digits value present that cycle (pre-increment if a tick coincides); lap in IDLE/DONE or with clear active SHALL be ignored; clear SHALL also zero lap_digits.
REQ-029 Without STOPWATCH_CTRL_LAP_EN: ports lap and lap_digits and their register SHALL be absent; all other behaviour SHALL be identical.

Verification (bench uses PRESCALE=4)
REQ-030 rst 2 cycles, start 1 cycle, target 0 -> running 1 next cycle; digits 0001 after 4 clks of RUN, 0010 after 40.
REQ-031 Preload via running to 0999, next tick -> digits 1000 in one cycle; from 9999 next tick -> 0000, done stays 0.
REQ-032 target 16'h0003, start -> done high exactly one cycle with digits 0003, running 0, further start ignored, clear -> digits 0000, IDLE.
REQ-033 stop at prescaler 2, hold 10 clks, start -> next tick after 2 more RUN clks; digits unchanged during PAUSE.
REQ-034 start, stop, clear all high in RUN -> IDLE, digits 0000; rst asserted mid-RUN at digits 0042 -> all outputs reset values next cycle.
REQ-035 With STOPWATCH_CTRL_LAP_EN: lap at digits 0017 coincident with tick -> lap_digits 0017, digits 0018; lap in IDLE -> lap_digits unchanged.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- four-digit BCD stopwatch with run/pause/target control.
//
// A 24-bit prescaler divides clk by PRESCALE to produce a count tick. On
// every tick in RUN, the four-digit BCD count increments with carry. It wraps
// from 9999 to 0000. When a valid nonzero target is reached, the block pulses
// done and parks in DONE until clear or rst.
//
// Parameters:
//   PRESCALE    clk cycles per count tick (2 .. 2^24)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       run request (level-sampled)
//   stop        pause request (level-sampled)
//   clear       return-to-zero request (level-sampled)
//   target      BCD target {d3,d2,d1,d0}; 16'h0000 or any nibble > 9 = free-run
//   lap         lap capture request        (only with STOPWATCH_CTRL_LAP_EN)
//   lap_digits  captured BCD count         (only with STOPWATCH_CTRL_LAP_EN)
//   digits      current BCD count {d3,d2,d1,d0}
//   running     high while in RUN
//   done        one-cycle pulse when the count reaches target
//
// Optional feature: define STOPWATCH_CTRL_LAP_EN to build the lap capture
// port pair and register.
//
// Request priority: rst > clear > stop > start.

module stopwatch_ctrl #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic [15:0] target,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  logic        lap,
    output logic [15:0] lap_digits,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [23:0] PRESCALE_LAST = 24'(PRESCALE - 1);

    logic [1:0]  state;
    logic [23:0] presc;
    logic        tick;
    logic        target_ok;
    logic        hit;
    logic [15:0] digits_inc;

    // BCD increment with ripple carry. A digit advances only when every lower
    // digit was 9. A digit at 9 that advances wraps to 0, so 9999 becomes 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] r;
        logic        carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A target containing a non-decimal nibble can never match the count.
    // This makes such a target behave as free-run.
    always_comb begin
        target_ok = (target != 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (target[i*4 +: 4] > 4'd9) begin
                target_ok = 1'b0;
            end
        end
    end

    assign tick       = (state == RUN) && (presc == PRESCALE_LAST);
    assign digits_inc = bcd_inc(digits);
    // target is only consulted here, so it is effectively sampled at tick.
    assign hit        = target_ok && (digits_inc == target);

    // NOTE: state registers use non-blocking assignments, so every branch
    // reads the pre-edge values of state, presc and digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            digits  <= 16'h0000;
            presc   <= 24'd0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            // done is a single-update pulse; it is only raised on a target hit.
            done <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                digits  <= 16'h0000;
                presc   <= 24'd0;
                running <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // stop outranks start, even though stop alone does
                        // nothing here.
                        if (start && !stop) begin
                            state   <= RUN;
                            presc   <= 24'd0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            // Freeze: a coincident tick is dropped, and presc holds.
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (tick) begin
                            presc  <= 24'd0;
                            digits <= digits_inc;
                            if (hit) begin
                                done    <= 1'b1;
                                state   <= DONE;
                                running <= 1'b0;
                            end
                        end else begin
                            presc <= presc + 24'd1;
                        end
                    end
                    PAUSE: begin
                        // Resume with the prescaler phase retained.
                        if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE: only clear or rst leave this state.
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    // The lap register captures the pre-update count. If a tick coincides,
    // the value shown is the one before the increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_digits <= 16'h0000;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            lap_digits <= digits;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl -- self-checking bench for stopwatch_ctrl with PRESCALE=4.
// The model keeps the count as a plain integer 0..9999 and converts it to BCD
// only for comparison. Directed phases pin key values with literals, and a
// randomized phase exercises request mixes and target changes.

module tb_stopwatch_ctrl;

    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] target = 16'h0000;
    logic [15:0] digits;
    logic        running;
    logic        done;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic        lap = 1'b0;
    logic [15:0] lap_digits;
`endif

    stopwatch_ctrl #(.PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .target     (target),
`ifdef STOPWATCH_CTRL_LAP_EN
        .lap        (lap),
        .lap_digits (lap_digits),
`endif
        .digits     (digits),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_cnt  = 0;     // count as a decimal integer
    int    m_pre  = 0;     // prescaler phase, 0..PRESCALE-1
    bit    m_done = 1'b0;
    int    m_lap  = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Decimal value of a matchable target, or -1 for free-run.
    function automatic int target_value(input logic [15:0] t);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            if (t[i*4 +: 4] > 4'd9) return -1;
            v = v * 10 + int'(t[i*4 +: 4]);
        end
        return (v == 0) ? -1 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs that were sampled at that edge.
    task automatic model_update();
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_done = 1'b0; m_lap = 0;
        end else begin
            m_done = 1'b0;
            if (clear) m_lap = 0;
`ifdef STOPWATCH_CTRL_LAP_EN
            else if (lap && (m_mode == M_RUN || m_mode == M_PAUSE)) m_lap = m_cnt;
`endif
            if (clear) begin
                m_mode = M_IDLE; m_cnt = 0; m_pre = 0;
            end else begin
                case (m_mode)
                    M_IDLE:  if (start && !stop) begin m_mode = M_RUN; m_pre = 0; end
                    M_PAUSE: if (start && !stop) m_mode = M_RUN;
                    M_RUN: begin
                        if (stop) m_mode = M_PAUSE;
                        else if (m_pre == PRESCALE - 1) begin
                            m_pre = 0;
                            m_cnt = (m_cnt + 1) % 10000;
                            if (m_cnt == target_value(target)) begin
                                m_done = 1'b1;
                                m_mode = M_DONE;
                            end
                        end else m_pre++;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: update the model at the edge, then compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("digits", digits, to_bcd(m_cnt));
        check("running", running, (m_mode == M_RUN));
        check("done", done, m_done);
`ifdef STOPWATCH_CTRL_LAP_EN
        check("lap_digits", lap_digits, to_bcd(m_lap));
`endif
    endtask

    // Step until the model reaches count c (and prescaler phase p, unless p < 0).
    task automatic run_until(input int c, input int p, input int limit);
        int n;
        n = 0;
        while (!(m_cnt == c && (p < 0 || m_pre == p)) && n < limit) begin
            step();
            n++;
        end
        if (!(m_cnt == c && (p < 0 || m_pre == p))) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout waiting for count %0d", c);
        end
    endtask

    initial begin
        logic [15:0] tgt_tab [6];
        int n;
        tgt_tab = '{16'h0000, 16'h0005, 16'h0012, 16'h0030, 16'h00A1, 16'h0007};

        // Reset state
        rst = 1'b1; step(); step();
        check("rst_digits", digits, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // Free-run: running rises the cycle after start, and one count occurs per 4 clocks.
        target = 16'h0000; start = 1'b1; step(); start = 1'b0;
        check("start_running", running, 1'b1);
        repeat (4) step();
        check("first_tick", digits, 16'h0001);
        repeat (36) step();
        check("forty_clks", digits, 16'h0010);

        // Carry ripple 0999 -> 1000, then wrap 9999 -> 0000 without done.
        run_until(1000, -1, 5000);
        check("carry_1000", digits, 16'h1000);
        run_until(9999, -1, 40000);
        run_until(0, -1, 10);
        check("wrap_0000", digits, 16'h0000);
        check("wrap_no_done", done, 1'b0);

        // Target match
        clear = 1'b1; step(); clear = 1'b0;
        target = 16'h0003; start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!done && n < 100) begin step(); n++; end
        check("done_pulse", done, 1'b1);
        check("done_digits", digits, 16'h0003);
        check("done_running", running, 1'b0);
        step();
        check("done_one_cycle", done, 1'b0);
        start = 1'b1; step(); start = 1'b0; step();
        check("done_start_ignored", running, 1'b0);
        check("done_hold_digits", digits, 16'h0003);
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_digits", digits, 16'h0000);
        check("clear_running", running, 1'b0);

        // Pause at prescaler phase 2; the phase is retained across the pause.
        target = 16'h0000; start = 1'b1; step(); start = 1'b0;
        run_until(2, 2, 100);
        stop = 1'b1; step(); stop = 1'b0;
        repeat (10) step();
        check("pause_digits", digits, 16'h0002);
        check("pause_running", running, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        check("resume_running", running, 1'b1);
        step();
        check("resume_no_tick", digits, 16'h0002);
        step();
        check("resume_tick", digits, 16'h0003);

        // Simultaneous requests: clear wins.
        start = 1'b1; stop = 1'b1; clear = 1'b1; step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        check("prio_digits", digits, 16'h0000);
        check("prio_running", running, 1'b0);

        // rst mid-RUN
        start = 1'b1; step(); start = 1'b0;
        run_until(42, -1, 400);
        check("pre_rst_digits", digits, 16'h0042);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrun_rst_digits", digits, 16'h0000);
        check("midrun_rst_running", running, 1'b0);

`ifdef STOPWATCH_CTRL_LAP_EN
        // Lap coincident with a tick captures the pre-increment count.
        start = 1'b1; step(); start = 1'b0;
        run_until(17, 3, 200);
        lap = 1'b1; step(); lap = 1'b0;
        check("lap_capture", lap_digits, 16'h0017);
        check("lap_digits_after", digits, 16'h0018);
        clear = 1'b1; step(); clear = 1'b0;
        lap = 1'b1; step(); lap = 1'b0;
        check("lap_idle_ignored", lap_digits, 16'h0000);
`endif

        // Randomized request mix with occasional target changes.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom % 300) == 0;
            clear = ($urandom % 60) == 0;
            stop  = ($urandom % 20) == 0;
            start = ($urandom % 8) == 0;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap   = ($urandom % 6) == 0;
`endif
            if (($urandom % 100) == 0) target = tgt_tab[$urandom_range(0, 5)];
            step();
        end
        rst = 1'b0; clear = 1'b0; stop = 1'b0; start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
